free_list: RTL and testbench

//  Circular FIFO of free physical register tags for the rename stage; sits upstream of map_table.

---
 rtl/free_list_if.sv | 25 ++
 rtl/free_list.sv | 119 +++++++++++
 tb/tb_free_list.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// Rename-stage <-> free list handshake: allocation requests/grants, retire frees,
// branch recovery and the registered free count.
interface free_list_if #(
    parameter int N   = 3,
    parameter int PRW = 6,
    parameter int CW  = 6
);
    logic [N-1:0]     alloc_req;
    logic [N*PRW-1:0] alloc_pr;
    logic             alloc_stall;
    logic [N-1:0]     free_en;
    logic [N*PRW-1:0] free_pr;
    logic             BPRecoverEN;
    logic [CW-1:0]    free_count;

    modport master (
        output alloc_req, free_en, free_pr, BPRecoverEN,
        input  alloc_pr, alloc_stall, free_count
    );

    modport slave (
        input  alloc_req, free_en, free_pr, BPRecoverEN,
        output alloc_pr, alloc_stall, free_count
    );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags: N-wide same-cycle allocation,
// N-wide retire frees, and recovery of the free set on a branch squash.
module free_list #(
    parameter int ARCH_COUNT = 32,
    parameter int PHYS_REGS  = 64,
    parameter int N          = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    free_list_if.slave   fl
);
    localparam int PRW   = (PHYS_REGS <= 2) ? 1 : $clog2(PHYS_REGS);
    localparam int DEPTH = PHYS_REGS - ARCH_COUNT;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

    logic [PRW-1:0]   entries_q [DEPTH];
    logic [PRW-1:0]   entries_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic             stall;
    logic [N*PRW-1:0] alloc_pr;
    logic [PW-1:0]    wr_idx [N];
    int               r_cnt;
    int               f_cnt;
    int               a_ofs;
    int               f_ofs;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int k);
        int s;
        s = (int'(p) + k) % DEPTH;
        return PW'(s);
    endfunction

    // Grants: the k-th requesting lane (scanning oldest lane first) takes head+k.
    always_comb begin
        r_cnt    = 0;
        f_cnt    = 0;
        a_ofs    = 0;
        alloc_pr = '0;
        for (int l = 0; l < N; l++) begin
            if (fl.alloc_req[l]) r_cnt++;
            if (fl.free_en[l])   f_cnt++;
        end
        stall = (r_cnt > int'(count_q)) || fl.BPRecoverEN;
        for (int l = N - 1; l >= 0; l--) begin
            if (fl.alloc_req[l]) begin
                if (!stall) alloc_pr[l*PRW +: PRW] = entries_q[ptr_add(head_q, a_ofs)];
                a_ofs++;
            end
        end
    end

    always_comb begin
        f_ofs = 0;
        for (int l = N - 1; l >= 0; l--) begin
            wr_idx[l] = ptr_add(tail_q, f_ofs);
            if (fl.free_en[l]) f_ofs++;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            for (int l = 0; l < N; l++) begin
                if (fl.free_en[l] && (wr_idx[l] == PW'(i)))
                    entries_d[i] = fl.free_pr[l*PRW +: PRW];
            end
        end
    end

    // Recovery discards every in-flight allocation: the free region restarts at the retire pointer.
    always_comb begin
        tail_d = ptr_add(tail_q, f_cnt);
        if (fl.BPRecoverEN) begin
            head_d  = tail_d;
            count_d = CW'(DEPTH);
        end else if (stall) begin
            head_d  = head_q;
            count_d = CW'(int'(count_q) + f_cnt);
        end else begin
            head_d  = ptr_add(head_q, r_cnt);
            count_d = CW'(int'(count_q) + f_cnt - r_cnt);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CW'(DEPTH);
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= PRW'(ARCH_COUNT + i);
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    assign fl.alloc_pr    = alloc_pr;
    assign fl.alloc_stall = stall;
    assign fl.free_count  = count_q;

    // More tags returned than outstanding means the retire/allocate pairing is broken upstream.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !fl.BPRecoverEN |-> ((int'(count_q) + f_cnt - (stall ? 0 : r_cnt)) <= DEPTH));

    a_count_range: assert property (@(posedge clock) disable iff (!reset_n)
        int'(count_q) <= DEPTH);

    for (genvar gi = 0; gi < N; gi++) begin : g_free_chk
        a_free_tag: assert property (@(posedge clock) disable iff (!reset_n)
            fl.free_en[gi] |-> (!$isunknown(fl.free_pr[gi*PRW +: PRW]) &&
                                (fl.free_pr[gi*PRW +: PRW] != '0)));
    end
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: a queue model of the free set and in-flight tags,
// checked every cycle, plus hand-computed expectations at the key points.
module tb_free_list;
    localparam int N   = 3;
    localparam int PRW = 6;
    localparam int CW  = 6;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    free_list_if #(.N(N), .PRW(PRW), .CW(CW)) fl();

    free_list #(.ARCH_COUNT(32), .PHYS_REGS(64), .N(N)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .fl      (fl)
    );

    always #5 clock = ~clock;

    // free_q: allocatable tags in grant order; infl_q: granted tags not yet retired, oldest first.
    int free_q[$];
    int infl_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    always @(posedge clock or negedge reset_n) begin : model_upd
        int r;
        int freed[$];
        int merged[$];
        if (!reset_n) begin
            free_q.delete();
            infl_q.delete();
            for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
        end else begin
            r = 0;
            freed.delete();
            for (int l = N - 1; l >= 0; l--) begin
                if (fl.alloc_req[l]) r++;
                if (fl.free_en[l]) freed.push_back(int'(fl.free_pr[l*PRW +: PRW]));
            end
            for (int i = 0; i < freed.size(); i++)
                if (infl_q.size() > 0) void'(infl_q.pop_front());
            if (fl.BPRecoverEN) begin
                merged.delete();
                foreach (infl_q[i]) merged.push_back(infl_q[i]);
                foreach (free_q[i]) merged.push_back(free_q[i]);
                foreach (freed[i])  merged.push_back(freed[i]);
                free_q = merged;
                infl_q.delete();
            end else begin
                if (r <= free_q.size())
                    for (int i = 0; i < r; i++) infl_q.push_back(free_q.pop_front());
                foreach (freed[i]) free_q.push_back(freed[i]);
            end
        end
    end

    always @(negedge clock) begin : compare
        int r;
        int k;
        logic exp_stall;
        logic [31:0] exp_pr;
        if (reset_n) begin
            r = 0;
            for (int l = 0; l < N; l++) if (fl.alloc_req[l]) r++;
            exp_stall = (r > free_q.size()) || fl.BPRecoverEN;
            exp_pr = '0;
            k = 0;
            for (int l = N - 1; l >= 0; l--) begin
                if (fl.alloc_req[l]) begin
                    if (!exp_stall) exp_pr[l*PRW +: PRW] = 6'(free_q[k]);
                    k++;
                end
            end
            chk("model_stall", 32'(fl.alloc_stall), 32'(exp_stall));
            chk("model_pr",    32'(fl.alloc_pr),    exp_pr);
            chk("model_count", 32'(fl.free_count),  32'(free_q.size()));
        end
    end

    function automatic logic [17:0] pk(input int a2, input int a1, input int a0);
        return {a2[5:0], a1[5:0], a0[5:0]};
    endfunction

    task automatic cyc(input logic [2:0] req, input logic [2:0] fen,
                       input logic [17:0] fpr, input logic rec);
        @(posedge clock);
        #1;
        fl.alloc_req   = req;
        fl.free_en     = fen;
        fl.free_pr     = fpr;
        fl.BPRecoverEN = rec;
        @(negedge clock);
        #1;
        $display("cyc t=%0t req=%b fen=%b rec=%b pr=%h stall=%b cnt=%0d",
                 $time, req, fen, rec, fl.alloc_pr, fl.alloc_stall, fl.free_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        fl.alloc_req   = 3'b111;
        fl.free_en     = '0;
        fl.free_pr     = '0;
        fl.BPRecoverEN = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_count", 32'(fl.free_count), 32);
        chk("rst_stall", 32'(fl.alloc_stall), 0);
        fl.alloc_req = '0;
        @(negedge clock);
        #1;
        reset_n = 1'b1;

        // First grant after reset, lane2 oldest
        cyc(3'b111, 3'b000, '0, 1'b0);
        chk("t1_pr", 32'(fl.alloc_pr), 32'({6'd32, 6'd33, 6'd34}));
        chk("t1_stall", 32'(fl.alloc_stall), 0);
        cyc(3'b000, 3'b000, '0, 1'b0);
        chk("t1_count", 32'(fl.free_count), 29);

        // Drain to two free tags, then an oversize request stalls
        for (int i = 0; i < 9; i++) cyc(3'b111, 3'b000, '0, 1'b0);
        cyc(3'b111, 3'b000, '0, 1'b0);
        chk("t2_count", 32'(fl.free_count), 2);
        chk("t2_stall", 32'(fl.alloc_stall), 1);
        chk("t2_pr0", 32'(fl.alloc_pr), 0);
        cyc(3'b101, 3'b000, '0, 1'b0);
        chk("t2_hold", 32'(fl.free_count), 2);
        chk("t2_pr", 32'(fl.alloc_pr), 32'({6'd62, 6'd0, 6'd63}));
        cyc(3'b000, 3'b001, pk(0, 0, 1), 1'b0);
        chk("t2_empty", 32'(fl.free_count), 0);

        // Same-cycle alloc and free at count=1
        cyc(3'b011, 3'b000, '0, 1'b0);
        chk("t4_stall2", 32'(fl.alloc_stall), 1);
        cyc(3'b010, 3'b011, pk(0, 2, 3), 1'b0);
        chk("t4_pr", 32'(fl.alloc_pr), 32'({6'd0, 6'd1, 6'd0}));
        cyc(3'b100, 3'b000, '0, 1'b0);
        chk("t4_count", 32'(fl.free_count), 2);
        chk("t4_next", 32'(fl.alloc_pr), 32'({6'd2, 6'd0, 6'd0}));

        // Build in-flight state, then recover with a same-cycle free
        for (int j = 0; j < 4; j++) cyc(3'b000, 3'b111, pk(4 + 3*j, 5 + 3*j, 6 + 3*j), 1'b0);
        for (int j = 0; j < 3; j++) cyc(3'b111, 3'b000, '0, 1'b0);
        cyc(3'b100, 3'b000, '0, 1'b0);
        cyc(3'b000, 3'b011, pk(0, 16, 17), 1'b0);
        cyc(3'b000, 3'b011, pk(0, 18, 19), 1'b0);
        cyc(3'b111, 3'b001, pk(0, 0, 20), 1'b1);
        chk("t5_stall", 32'(fl.alloc_stall), 1);
        chk("t5_pr", 32'(fl.alloc_pr), 0);
        cyc(3'b100, 3'b000, '0, 1'b0);
        chk("t5_count", 32'(fl.free_count), 32);
        chk("t5_first", 32'(fl.alloc_pr), 32'({6'd52, 6'd0, 6'd0}));

        // Head wrap: head 30 -> slots 30,31,0
        for (int j = 0; j < 3; j++) cyc(3'b111, 3'b000, '0, 1'b0);
        cyc(3'b111, 3'b000, '0, 1'b0);
        chk("t3_wrap", 32'(fl.alloc_pr), 32'({6'd62, 6'd63, 6'd1}));

        // Tail wrap: advance tail to 31, free {5,6,7} into slots 31,0,1
        for (int j = 0; j < 3; j++) cyc(3'b000, 3'b111, pk(21 + 3*j, 22 + 3*j, 23 + 3*j), 1'b0);
        cyc(3'b000, 3'b011, pk(0, 30, 31), 1'b0);
        cyc(3'b111, 3'b000, '0, 1'b0);
        chk("t3_pre", 32'(fl.alloc_pr), 32'({6'd2, 6'd3, 6'd4}));
        cyc(3'b000, 3'b111, pk(5, 6, 7), 1'b0);
        cyc(3'b000, 3'b000, '0, 1'b0);
        chk("t3_count", 32'(fl.free_count), 30);
        for (int j = 0; j < 9; j++) cyc(3'b111, 3'b000, '0, 1'b0);
        cyc(3'b111, 3'b000, '0, 1'b0);
        chk("t3_freewrap", 32'(fl.alloc_pr), 32'({6'd5, 6'd6, 6'd7}));

        // Asynchronous reset in the middle of a granted allocation
        cyc(3'b000, 3'b111, pk(8, 9, 10), 1'b0);
        cyc(3'b111, 3'b000, '0, 1'b0);
        chk("t6_grant", 32'(fl.alloc_stall), 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async", 32'(fl.free_count), 32);
        fl.alloc_req = '0;
        fl.free_en   = '0;
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        cyc(3'b100, 3'b000, '0, 1'b0);
        chk("t6_first", 32'(fl.alloc_pr), 32'({6'd32, 6'd0, 6'd0}));
        cyc(3'b000, 3'b000, '0, 1'b0);
        chk("t6_count", 32'(fl.free_count), 31);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
